// File: rtl/run_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// run_sequencer_pkg
// Shared types and default widths for the run sequencer and its watchdog.
//   state_e      : sequencer FSM state, 3-bit encoding exported on the port
//   ADDR_W_DEF   : default program memory address width
//   DATA_W_DEF   : default program / result byte width
// ----------------------------------------------------------------------------
package run_sequencer_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ARMED = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/run_sequencer_watchdog.sv
// ----------------------------------------------------------------------------
// seq_watchdog
// Counts RUN cycles and flags the cycle in which the budget is used up.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : restart the count at 0 (takes priority over enable)
//   enable      : count this cycle
//   expired     : count has reached WDOG_CYCLES-1 while enabled
// ----------------------------------------------------------------------------
module seq_watchdog #(
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (WDOG_CYCLES < 2) ? 1 : $clog2(WDOG_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'((WDOG_CYCLES == 0) ? 0 : WDOG_CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             at_last;

    assign at_last = (count_q == LAST);
    assign expired = enable & at_last;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !at_last) begin
            // Hold at the last value so the counter can never wrap.
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/run_sequencer.sv
// ----------------------------------------------------------------------------
// run_sequencer
// Loads a program from a host byte stream into a byte computer's program
// memory, starts it on request, and captures its output byte when it halts
// (or flags a timeout when the watchdog expires).
//   clk, rst_n                         : clock, asynchronous active-low reset
//   host_valid/host_data/host_last     : program byte stream from host
//   host_ready                         : byte accepted this cycle
//   go, abort                          : run request / return to IDLE
//   cpu_start, cpu_halt                : run enable / halted indication
//   cpu_we, cpu_addr, cpu_wdata        : program memory write port
//   cpu_odata                          : computer output byte
//   result, result_valid, timeout      : captured outcome of the last run
//   state                              : current FSM state code
// ----------------------------------------------------------------------------
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_valid,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_last,
    output logic              host_ready,
    input  logic              go,
    input  logic              abort,
    output logic              cpu_start,
    input  logic              cpu_halt,
    output logic              cpu_we,
    output logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W-1:0] cpu_odata,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              timeout,
    output logic [2:0]        state
);

    localparam logic [ADDR_W-1:0] PTR_MAX = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              start_q, start_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              rvalid_q, rvalid_d;
    logic              tout_q, tout_d;

    logic hs;
    logic wd_clear;
    logic wd_expired;

    // Ready is a pure decode of the registered state, so it is glitch-free
    // and reads 1 during reset (state is IDLE).
    assign host_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DONE);
    assign hs         = host_valid & host_ready;

    seq_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wd_clear),
        .enable  (state_q == ST_RUN),
        .expired (wd_expired)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        start_d  = start_q;
        result_d = result_q;
        rvalid_d = rvalid_q;
        tout_d   = tout_q;
        wd_clear = 1'b0;

        if (abort) begin
            // Overrides everything, including a handshake in this cycle.
            state_d = ST_IDLE;
            ptr_d   = '0;
            start_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    // A new program load wins over a rerun request in DONE,
                    // since the byte has already been acknowledged.
                    if (hs) begin
                        we_d     = 1'b1;
                        addr_d   = '0;
                        wdata_d  = host_data;
                        ptr_d    = (PTR_MAX == '0) ? '0 : ADDR_W'(1);
                        rvalid_d = 1'b0;
                        tout_d   = 1'b0;
                        state_d  = (host_last || PTR_MAX == '0) ? ST_ARMED : ST_LOAD;
                    end else if (state_q == ST_DONE && go) begin
                        state_d  = ST_RUN;
                        start_d  = 1'b1;
                        wd_clear = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = host_data;
                        if (host_last || ptr_q == PTR_MAX) begin
                            state_d = ST_ARMED;
                        end else begin
                            ptr_d = ptr_q + ADDR_W'(1);
                        end
                    end
                end
                ST_ARMED: begin
                    if (go) begin
                        state_d  = ST_RUN;
                        start_d  = 1'b1;
                        wd_clear = 1'b1;
                    end
                end
                ST_RUN: begin
                    // Halt is checked first so a coincident expiry is ignored.
                    if (cpu_halt) begin
                        result_d = cpu_odata;
                        rvalid_d = 1'b1;
                        tout_d   = 1'b0;
                        start_d  = 1'b0;
                        state_d  = ST_DONE;
                    end else if (wd_expired) begin
                        rvalid_d = 1'b0;
                        tout_d   = 1'b1;
                        start_d  = 1'b0;
                        state_d  = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    start_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            start_q  <= 1'b0;
            result_q <= '0;
            rvalid_q <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            start_q  <= start_d;
            result_q <= result_d;
            rvalid_q <= rvalid_d;
            tout_q   <= tout_d;
        end
    end

    assign cpu_start    = start_q;
    assign cpu_we       = we_q;
    assign cpu_addr     = addr_q;
    assign cpu_wdata    = wdata_q;
    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign timeout      = tout_q;
    assign state        = state_q;

endmodule

// File: tb/tb_run_sequencer.sv
// ----------------------------------------------------------------------------
// tb_run_sequencer
// Directed bench for run_sequencer with default parameters
// (ADDR_W=5, DATA_W=8, WDOG_CYCLES=255).
// ----------------------------------------------------------------------------
module tb_run_sequencer;

    logic       clk;
    logic       rst_n;
    logic       host_valid;
    logic [7:0] host_data;
    logic       host_last;
    logic       host_ready;
    logic       go;
    logic       abort;
    logic       cpu_start;
    logic       cpu_halt;
    logic       cpu_we;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_odata;
    logic [7:0] result;
    logic       result_valid;
    logic       timeout;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    run_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_valid   (host_valid),
        .host_data    (host_data),
        .host_last    (host_last),
        .host_ready   (host_ready),
        .go           (go),
        .abort        (abort),
        .cpu_start    (cpu_start),
        .cpu_halt     (cpu_halt),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_odata    (cpu_odata),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; host_valid = 1'b0; host_data = 8'h00; host_last = 1'b0;
        go = 1'b0; abort = 1'b0; cpu_halt = 1'b0; cpu_odata = 8'h00;

        // ---- reset state
        #3;
        chk("rst_state",  32'(state), 32'd0);
        chk("rst_ready",  32'(host_ready), 32'd1);
        chk("rst_start",  32'(cpu_start), 32'd0);
        chk("rst_we",     32'(cpu_we), 32'd0);
        chk("rst_addr",   32'(cpu_addr), 32'd0);
        chk("rst_wdata",  32'(cpu_wdata), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rvalid", 32'(result_valid), 32'd0);
        chk("rst_tout",   32'(timeout), 32'd0);
        #9 rst_n = 1'b1;
        tick();
        chk("idle_after_rst", 32'(state), 32'd0);

        // ---- go in IDLE is ignored
        go = 1'b1; tick(); go = 1'b0;
        chk("go_idle_ignored", 32'(state), 32'd0);

        // ---- load 0x11,0x22,0x33
        host_valid = 1'b1; host_data = 8'h11; tick();
        chk("ld0_we", 32'(cpu_we), 32'd1);
        chk("ld0_addr", 32'(cpu_addr), 32'd0);
        chk("ld0_data", 32'(cpu_wdata), 32'h11);
        chk("ld0_state", 32'(state), 32'd1);
        host_data = 8'h22; tick();
        chk("ld1_we", 32'(cpu_we), 32'd1);
        chk("ld1_addr", 32'(cpu_addr), 32'd1);
        chk("ld1_data", 32'(cpu_wdata), 32'h22);
        host_data = 8'h33; host_last = 1'b1; tick();
        chk("ld2_we", 32'(cpu_we), 32'd1);
        chk("ld2_addr", 32'(cpu_addr), 32'd2);
        chk("ld2_data", 32'(cpu_wdata), 32'h33);
        chk("ld2_state", 32'(state), 32'd2);
        chk("ld2_ready", 32'(host_ready), 32'd0);
        host_valid = 1'b0; host_last = 1'b0; tick();
        chk("armed_we_low", 32'(cpu_we), 32'd0);
        chk("armed_hold", 32'(state), 32'd2);
        chk("armed_halt_ign", 32'(result_valid), 32'd0);

        // ---- run, halt on 10th RUN cycle with 0xA5
        go = 1'b1; tick(); go = 1'b0;
        chk("run_state", 32'(state), 32'd3);
        chk("run_start", 32'(cpu_start), 32'd1);
        chk("run_ready", 32'(host_ready), 32'd0);
        for (int i = 0; i < 9; i++) tick();
        chk("run_still", 32'(state), 32'd3);
        cpu_halt = 1'b1; cpu_odata = 8'hA5; tick(); cpu_halt = 1'b0; cpu_odata = 8'h00;
        chk("halt_state", 32'(state), 32'd4);
        chk("halt_result", 32'(result), 32'hA5);
        chk("halt_rvalid", 32'(result_valid), 32'd1);
        chk("halt_start", 32'(cpu_start), 32'd0);
        chk("halt_tout", 32'(timeout), 32'd0);
        // halt outside RUN must not recapture
        cpu_halt = 1'b1; cpu_odata = 8'h5A; tick(); cpu_halt = 1'b0;
        chk("done_halt_ign", 32'(result), 32'hA5);
        chk("done_hold", 32'(state), 32'd4);

        // ---- rerun from DONE, watchdog expiry after 255 cycles
        go = 1'b1; tick(); go = 1'b0;
        chk("rerun_start", 32'(cpu_start), 32'd1);
        for (int i = 0; i < 254; i++) tick();
        chk("wd_254_run", 32'(state), 32'd3);
        chk("wd_254_tout", 32'(timeout), 32'd0);
        tick();
        chk("wd_tout", 32'(timeout), 32'd1);
        chk("wd_rvalid", 32'(result_valid), 32'd0);
        chk("wd_start", 32'(cpu_start), 32'd0);
        chk("wd_state", 32'(state), 32'd4);

        // ---- 32 bytes without last fills memory, then stalls
        host_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            host_data = 8'(8'h40 + i);
            tick();
            chk("fill_we", 32'(cpu_we), 32'd1);
            chk("fill_addr", 32'(cpu_addr), 32'(i));
            chk("fill_data", 32'(cpu_wdata), 32'(8'h40 + i));
            if (i == 0) chk("fill_tout_clr", 32'(timeout), 32'd0);
        end
        chk("fill_armed", 32'(state), 32'd2);
        chk("fill_ready", 32'(host_ready), 32'd0);
        host_data = 8'hEE; tick();
        chk("fill_stall_we", 32'(cpu_we), 32'd0);
        chk("fill_stall_st", 32'(state), 32'd2);
        host_valid = 1'b0;

        // ---- abort from ARMED, then abort after 5 bytes with a byte in flight
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_idle", 32'(state), 32'd0);
        chk("abort_keep_res", 32'(result), 32'hA5);
        host_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            host_data = 8'(8'h60 + i);
            tick();
            chk("ab_ld_addr", 32'(cpu_addr), 32'(i));
        end
        host_data = 8'h99; abort = 1'b1; tick(); abort = 1'b0; host_valid = 1'b0;
        chk("abort2_idle", 32'(state), 32'd0);
        chk("abort2_we_drop", 32'(cpu_we), 32'd0);
        host_valid = 1'b1; host_data = 8'h77; host_last = 1'b1; tick();
        host_valid = 1'b0; host_last = 1'b0;
        chk("reload_addr", 32'(cpu_addr), 32'd0);
        chk("reload_data", 32'(cpu_wdata), 32'h77);
        chk("reload_armed", 32'(state), 32'd2);

        // ---- halt coincident with watchdog expiry: halt wins
        go = 1'b1; tick(); go = 1'b0;
        for (int i = 0; i < 254; i++) tick();
        chk("coin_pre", 32'(state), 32'd3);
        cpu_halt = 1'b1; cpu_odata = 8'h3C; tick(); cpu_halt = 1'b0;
        chk("coin_state", 32'(state), 32'd4);
        chk("coin_result", 32'(result), 32'h3C);
        chk("coin_rvalid", 32'(result_valid), 32'd1);
        chk("coin_tout", 32'(timeout), 32'd0);

        // ---- asynchronous reset mid-RUN
        go = 1'b1; tick(); go = 1'b0;
        tick(); tick();
        chk("arst_pre_run", 32'(cpu_start), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_start", 32'(cpu_start), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_rvalid", 32'(result_valid), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("arst_post", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
